// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the rejection-sampling stimulus generator.
package constraint_sampler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CHECK,
    HOLD,
    FAIL
  } state_t;

  // Galois taps for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form)
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  function automatic int unsigned nwords(input int unsigned vec_w);
    return (vec_w + 32'd63) / 32'd64;
  endfunction

endpackage

// File: rtl/sampler_lfsr64.sv
// 64-bit Galois LFSR with synchronous load; a zero load value falls back to SEED.
module sampler_lfsr64
  import constraint_sampler_pkg::*;
#(
  parameter logic [63:0] SEED = 64'hACE1_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [63:0] load_val,
  output logic [63:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      // an all-zero state would lock the register, so substitute SEED
      q <= (load_val == '0) ? SEED : load_val;
    end else if (en) begin
      q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    end
  end

endmodule

// File: rtl/constraint_sampler.sv
// Fills a candidate vector from the LFSR one 64-bit word per cycle, checks it
// against an external constraint checker and streams out passing vectors.
module constraint_sampler
  import constraint_sampler_pkg::*;
#(
  parameter int unsigned VEC_W     = 779,
  parameter logic [63:0] SEED      = 64'hACE1_0000_0000_0001,
  parameter int unsigned MAX_TRIES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             seed_load,
  input  logic [63:0]      seed,
  output logic [VEC_W-1:0] cand,
  input  logic             chk_ok,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [VEC_W-1:0] sample_data,
  output logic             busy,
  output logic             fail,
  output logic [31:0]      tries
);

  localparam int unsigned NWORDS = nwords(VEC_W);
  localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(NWORDS - 1);
  localparam logic [31:0]       TRIES_LAST = 32'(MAX_TRIES - 1);

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   word_idx;
  logic [63:0]         lfsr_q;
  logic                lfsr_en, lfsr_load;
  logic [VEC_W-1:0]    cand_next;

  sampler_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (lfsr_en),
    .load     (lfsr_load),
    .load_val (seed),
    .q        (lfsr_q)
  );

  // Bit-wise word select keeps the truncated top word free of unused padding.
  always_comb begin
    cand_next = cand;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      if (word_idx == WIDX_W'(i / 64)) cand_next[i] = lfsr_q[i % 64];
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_en   = 1'b0;
    lfsr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        lfsr_load = seed_load;
        if (run) state_d = FILL;
      end
      FILL: begin
        lfsr_en = 1'b1;
        if (word_idx == LAST_WORD) state_d = CHECK;
      end
      CHECK: begin
        if (chk_ok)                   state_d = HOLD;
        else if (tries == TRIES_LAST) state_d = FAIL;
        else if (run)                 state_d = FILL;
        else                          state_d = IDLE;
      end
      HOLD: begin
        if (sample_ready) state_d = run ? FILL : IDLE;
      end
      FAIL: begin
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_idx    <= '0;
      tries       <= '0;
      cand        <= '0;
      sample_data <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (run) begin
            word_idx <= '0;
            tries    <= '0;
          end
        end
        FILL: begin
          cand     <= cand_next;
          word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + 1'b1;
        end
        CHECK: begin
          if (chk_ok)                    sample_data <= cand;
          else if (tries != TRIES_LAST)  tries       <= tries + 32'd1;
        end
        HOLD: begin
          if (sample_ready && run) tries <= '0;
        end
        default: ;
      endcase
    end
  end

  assign sample_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign fail         = (state_q == FAIL);

endmodule

// File: tb/tb_constraint_sampler.sv
// Directed bench for constraint_sampler with a scoreboard of expected samples.
module tb_constraint_sampler;

  localparam int unsigned VW    = 128;
  localparam logic [63:0] SEEDV = 64'h1;
  localparam int unsigned MAXT  = 4;
  localparam logic [63:0] TAPS  = 64'hD800_0000_0000_0000;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          seed_load;
  logic [63:0]   seed;
  logic [VW-1:0] cand;
  logic          chk_ok;
  logic          sample_valid;
  logic          sample_ready;
  logic [VW-1:0] sample_data;
  logic          busy;
  logic          fail;
  logic [31:0]   tries;

  int mode;  // 0: always pass, 1: always fail, 2: pass when cand[0]

  typedef struct {
    logic [VW-1:0] data;
    logic [31:0]   ntries;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_s;
  int          ncomp = 0;
  int          nfail = 0;

  constraint_sampler #(
    .VEC_W     (VW),
    .SEED      (SEEDV),
    .MAX_TRIES (MAXT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .seed_load    (seed_load),
    .seed         (seed),
    .cand         (cand),
    .chk_ok       (chk_ok),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .busy         (busy),
    .fail         (fail),
    .tries        (tries)
  );

  assign chk_ok = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : cand[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] nxt(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  task automatic gen(output logic [VW-1:0] c);
    logic [63:0] w0, w1;
    w0  = m_s;
    m_s = nxt(m_s);
    w1  = m_s;
    m_s = nxt(m_s);
    c   = {w1, w0};
  endtask

  task automatic push(input logic [VW-1:0] c, input logic [31:0] t);
    exp_t e;
    e.data   = c;
    e.ntries = t;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!sample_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, sample_valid, 1);
  endtask

  // Scoreboard side: every handshake must match the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      ncomp++;
      assert (sb.size() != 0) else begin
        nfail++;
        $error("FAIL sb_underflow: observed sample %0h with no expected entry", sample_data);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sample_data", sample_data, e.data);
        chk("sample_tries", tries, e.ntries);
      end
    end
  end

  initial begin
    logic [VW-1:0] c, c2;
    logic          passed;
    int unsigned   r;

    rst_n = 1'b0; run = 1'b0; seed_load = 1'b0; seed = '0;
    sample_ready = 1'b0; mode = 0;
    repeat (3) tick();
    chk("rst_cand", cand, 0);
    chk("rst_sample_data", sample_data, 0);
    chk("rst_tries", tries, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fail", fail, 0);
    m_s = SEEDV;
    rst_n = 1'b1;
    tick();

    // Always-pass, run held: valid on the 4th edge, next sample 4 edges later.
    mode = 0; sample_ready = 1'b1;
    gen(c);  push(c, 0);
    gen(c2); push(c2, 0);
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("pass_valid_timing", sample_valid, (i == 4 || i == 8));
      if (i == 1) chk("pass_busy_rise", busy, 1);
      if (i == 4) begin
        chk("pass_first_lo", sample_data[63:0], 64'h1);
        chk("pass_first_hi", sample_data[127:64], 64'hD800_0000_0000_0000);
      end
      if (i == 8) run = 1'b0;
    end
    tick();
    chk("pass_busy_fall", busy, 0);
    chk("pass_valid_fall", sample_valid, 0);

    // Always-fail: four rejects, fail after the 13th edge with tries=3.
    mode = 1;
    for (int k = 0; k < 4; k++) gen(c);
    run = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      chk("fail_timing", fail, (i == 13));
      chk("fail_no_valid", sample_valid, 0);
      if (i == 4) chk("fail_tries_1", tries, 1);
    end
    chk("fail_tries_sat", tries, 3);
    repeat (2) tick();
    chk("fail_sticky", fail, 1);
    chk("fail_tries_hold", tries, 3);
    run = 1'b0;
    tick();
    chk("fail_clear", fail, 0);
    chk("fail_idle", busy, 0);

    // Run dropped mid-FILL with a rejected candidate: back to IDLE.
    gen(c);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    chk("drop_check_busy", busy, 1);
    tick();
    chk("drop_idle", busy, 0);
    chk("drop_tries", tries, 1);
    chk("drop_no_fail", fail, 0);

    // Backpressure: five stalled HOLD cycles, handshake on the sixth.
    mode = 0; sample_ready = 1'b0;
    gen(c); push(c, 0);
    run = 1'b1;
    repeat (4) tick();
    chk("bp_valid", sample_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid_held", sample_valid, 1);
      chk("bp_data_held", sample_data, c);
    end
    sample_ready = 1'b1;
    tick();
    chk("bp_after_hs_valid", sample_valid, 0);
    chk("bp_after_hs_busy", busy, 1);
    gen(c2); push(c2, 0);
    run = 1'b0;
    wait_idle("bp_idle");

    // Zero seed_load with run reloads SEED; a seed_load during FILL is ignored.
    seed = '0; seed_load = 1'b1; run = 1'b1;
    m_s = SEEDV;
    gen(c);  push(c, 0);
    gen(c2); push(c2, 0);
    tick();
    seed = 64'hDEAD_BEEF_0000_1234; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      tick();
      chk("seed_valid_timing", sample_valid, (i == 4 || i == 8));
      if (i == 4) chk("seed_first_lo", sample_data[63:0], 64'h1);
      if (i == 8) run = 1'b0;
    end
    tick();
    chk("seed_idle", busy, 0);

    // Bit-0 checker from a loaded seed, tries predicted by the model.
    seed = 64'h0123_4567_89AB_CDEF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m_s = 64'h0123_4567_89AB_CDEF;
    mode = 2; run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r = 0; passed = 1'b0;
      while (1) begin
        gen(c);
        if (c[0]) begin
          push(c, r);
          passed = 1'b1;
          break;
        end
        if (r == MAXT - 1) break;
        r++;
      end
      if (passed) begin
        wait_valid("bit0_valid");
        chk("bit0_lsb", sample_data[0], 1);
        if (k == 2) run = 1'b0;
        tick();
      end else begin
        int n;
        n = 0;
        while (!fail && n < 50) begin
          tick();
          n++;
        end
        chk("bit0_fail", fail, 1);
        chk("bit0_fail_tries", tries, MAXT - 1);
        run = 1'b0;
        tick();
        break;
      end
    end
    run = 1'b0;
    wait_idle("bit0_idle");

    // Reset during the second FILL word, then restart from SEED.
    mode = 0; sample_ready = 1'b1;
    gen(c);
    run = 1'b1;
    tick();
    tick();
    chk("mid_fill_w0", cand[63:0], c[63:0]);
    rst_n = 1'b0; run = 1'b0;
    tick();
    chk("rst2_cand", cand, 0);
    chk("rst2_sample_data", sample_data, 0);
    chk("rst2_tries", tries, 0);
    chk("rst2_valid", sample_valid, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_fail", fail, 0);
    rst_n = 1'b1;
    m_s = SEEDV;
    gen(c); push(c, 0);
    run = 1'b1;
    tick();
    wait_valid("rst2_valid_after");
    chk("rst2_restart_lo", sample_data[63:0], 64'h1);
    run = 1'b0;
    tick();
    wait_idle("rst2_idle");

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/constraint_sampler.md
# constraint_sampler

Rejection-sampling stimulus generator paired with a generated constraint-checker module. Produces pseudo-random candidate assignment vectors from a 64-bit LFSR and drives them onto the checker's concatenated inputs. It samples the checker's single `x` result and emits only passing vectors on a valid/ready output stream. A per-sample retry budget terminates unsatisfiable or over-constrained runs.

## Interface
- `VEC_W`, default 779: total candidate width (concatenation of all checker inputs, var_0 at LSB).
- `SEED`, default 64'hACE1_0000_0000_0001: LFSR reset value, and the substitute for any zero seed.
- `MAX_TRIES`, default 1024: candidates tried per sample before failing, range 1..2^32-1.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `run` in 1: level; sampling proceeds while high.
- `seed_load` in 1: loads `seed` into the LFSR; honoured only in IDLE.
- `seed` in 64: new LFSR state.
- `cand` out VEC_W: candidate vector, wired to the checker inputs.
- `chk_ok` in 1: checker `x`, combinational function of `cand`.
- `sample_valid` out 1: accepted sample available.
- `sample_ready` in 1: downstream accepts the sample.
- `sample_data` out VEC_W: accepted vector.
- `busy` out 1: state is not IDLE.
- `fail` out 1: retry budget exhausted (sticky).
- `tries` out 32: candidates rejected so far for the current sample.

## Operation
- NWORDS = ceil(VEC_W/64). Fill word k occupies `cand[64k+63:64k]`. The top word is truncated at VEC_W.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1, advances exactly once per FILL cycle. The emitted word is the state before the step.
- A `seed_load` of 0 loads SEED instead.
- FSM states:
  - IDLE: `run` -> FILL, with word index and `tries` cleared.
  - FILL: writes one word per cycle, word 0 first. After word NWORDS-1 -> CHECK.
  - CHECK: registers `chk_ok` against the stable `cand`.
    - `chk_ok`=1: `sample_data` <= `cand`, go to HOLD.
    - `chk_ok`=0: `tries`++. If `tries`+1 == MAX_TRIES -> FAIL, else -> FILL.
  - HOLD: `sample_valid`=1. On `sample_valid & sample_ready`: if `run` -> FILL with `tries`=0, else -> IDLE.
  - FAIL: `fail`=1. `run`=0 -> IDLE, clearing `fail`.
- `run` deasserting during FILL or CHECK completes the current candidate. If it passes, the block still goes to HOLD (no sample is dropped). If it fails, the block goes to IDLE rather than FILL.
- Output stream rule: `sample_data` is constant while `sample_valid` is high and `sample_ready` is low. `sample_valid` does not drop without a handshake.
- `tries` saturates only through the FAIL transition and never wraps.

## Timing
- Reset values:
  - `cand`, `sample_data`, `tries`: 0.
  - `sample_valid`, `busy`, `fail`: 0.
  - LFSR: SEED. State: IDLE.
- Reset asserted in any state overrides everything on that edge, including mid-FILL and during HOLD. A pending sample is discarded.
- First-pass latency: with `run` sampled high in IDLE at edge 0, `sample_valid` is high after edge NWORDS+2.
- Each rejected candidate costs NWORDS+1 cycles.
- Back-to-back throughput: one sample per NWORDS+2 cycles when the first candidate passes and `sample_ready` is held high.
- `busy` rises on the edge leaving IDLE and falls on the edge entering IDLE.
- `seed_load` together with `run` in IDLE: the seed loads first, and the first FILL word is the loaded seed.

## Structure
- Package `constraint_sampler_pkg`: state enum (IDLE, FILL, CHECK, HOLD, FAIL), LFSR tap constant 64'hD800_0000_0000_0000, and the `nwords(VEC_W)` function.
- Sub-module `sampler_lfsr64`: ports `en`, `load`, `load_val`, `q`. The zero-seed substitution lives there.
- The FSM, word counter, tries counter and output registers live in the top level.

## Test plan
- Always-pass stub, VEC_W=128, SEED=1, `run` held high:
  - `sample_valid` after edge 4.
  - `sample_data` = {LFSR state after 1 step, 64'h1}.
  - Next sample 4 cycles later.
- Always-fail stub, MAX_TRIES=4, VEC_W=128: `fail` after 12 cycles in FILL/CHECK, `tries`=3, `sample_valid` never high. Dropping `run` returns to IDLE with `fail`=0.
- Checker stub passing only when bit 0 of `cand` is 1: every `sample_data[0]`=1, and `tries` matches the number of rejected candidates in a reference LFSR model.
- Backpressure: `sample_ready` low for 5 cycles in HOLD -> `sample_data` and `sample_valid` unchanged. Handshake on cycle 6 -> FILL.
- `seed_load`: loading 0 reproduces the SEED sequence. A `seed_load` in FILL is ignored and the sequence is unchanged.
- `rst_n`=0 mid-FILL (word 1 of 2): all outputs 0 and state IDLE next cycle. After release, the sequence restarts from SEED.
